ifetch_unit: RTL and testbench

Instruction fetch and status stage directly upstream of the microsequencer. It owns the program counter and runs a req/ack read on the memory bus when microcode asks for a fetch. It latches the returned word into the instruction register, whose opcode field drives the sequencer's `opcode` input. It also holds the carry/zero status flags that feed the sequencer's `carry` and `zero` inputs.

---
 rtl/ifetch_unit_if.sv | 33 +++
 rtl/ifetch_unit.sv | 139 +++++++++++++
 tb/tb_ifetch_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if
// Memory read bus between the instruction fetch stage and program memory.
// Handshake: the fetch stage (master) raises memReq and holds memAddr
// stable until it samples memAck high on a rising clock edge; memData is
// valid in every cycle where memAck is high. memAck seen while memReq is
// low is ignored by the master.
//   memReq   master -> slave  read request
//   memAddr  master -> slave  read address
//   memAck   slave  -> master acknowledge, qualifies memData
//   memData  slave  -> master read data
interface ifetch_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memAck;
  logic [DATA_WIDTH-1:0] memData;

  modport master (
    output memReq,
    output memAddr,
    input  memAck,
    input  memData
  );

  modport slave (
    input  memReq,
    input  memAddr,
    output memAck,
    output memData
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction fetch and status stage feeding the microsequencer. Owns the
// program counter, runs one req/ack memory read per fetchStart, latches the
// returned word into the instruction register and holds the carry/zero flags.
// Ports:
//   clock, notReset        clock and asynchronous active-low reset
//   fetchStart             request one instruction fetch
//   pcLoad, pcIn           load PC with a jump/branch target (not in FETCH)
//   flagsLoad              capture aluCarry/aluZero on the edge
//   aluCarry, aluZero      ALU status inputs
//   mem (master modport)   memReq/memAddr out, memAck/memData in
//   opcode, operand        IR fields
//   carry, zero            registered flags
//   irValid                one-cycle pulse after the IR is updated
//   stall                  high while a fetch is in progress
//   dbgState               current FSM state (0 IDLE, 1 FETCH, 2 DONE)
module ifetch_unit #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                         clock,
  input  logic                         notReset,
  input  logic                         fetchStart,
  input  logic                         pcLoad,
  input  logic [ADDR_WIDTH-1:0]        pcIn,
  input  logic                         flagsLoad,
  input  logic                         aluCarry,
  input  logic                         aluZero,
  ifetch_unit_if.master                mem,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic                         carry,
  output logic                         zero,
  output logic                         irValid,
  output logic                         stall,
  output logic [1:0]                   dbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ir;
  logic                  r_mem_req;
  logic                  r_stall;
  logic                  r_ir_valid;
  logic                  r_carry;
  logic                  r_zero;

  // The status outputs are flops loaded with the decode of the next state,
  // so they always equal a decode of r_state and never see input glitches.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET;
      r_ir       <= '0;
      r_mem_req  <= 1'b0;
      r_stall    <= 1'b0;
      r_ir_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pcLoad) begin
            r_pc <= pcIn;
          end
          if (fetchStart) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
            r_stall   <= 1'b1;
          end
        end

        // PC is frozen here (pcLoad ignored) so memAddr stays stable for
        // the whole request; extra fetchStart pulses are dropped.
        S_FETCH: begin
          if (mem.memAck) begin
            r_ir       <= mem.memData;
            r_pc       <= r_pc + 1'b1;
            r_state    <= S_DONE;
            r_mem_req  <= 1'b0;
            r_stall    <= 1'b0;
            r_ir_valid <= 1'b1;
          end
        end

        // A pcLoad here overrides the post-fetch PC; a fetch started in the
        // same cycle therefore reads from the new target.
        S_DONE: begin
          r_ir_valid <= 1'b0;
          if (pcLoad) begin
            r_pc <= pcIn;
          end
          if (fetchStart) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
            r_stall   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_mem_req  <= 1'b0;
          r_stall    <= 1'b0;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  // Flags are independent of the fetch state machine.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (flagsLoad) begin
      r_carry <= aluCarry;
      r_zero  <= aluZero;
    end
  end

  assign mem.memReq  = r_mem_req;
  assign mem.memAddr = r_pc;
  assign opcode      = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand     = r_ir[DATA_WIDTH-OPCODE_WIDTH-1:0];
  assign carry       = r_carry;
  assign zero        = r_zero;
  assign irValid     = r_ir_valid;
  assign stall       = r_stall;
  assign dbgState    = r_state;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clock;
  logic        notReset;
  logic        fetchStart;
  logic        pcLoad;
  logic [15:0] pcIn;
  logic        flagsLoad;
  logic        aluCarry;
  logic        aluZero;
  logic [6:0]  opcode;
  logic [8:0]  operand;
  logic        carry;
  logic        zero;
  logic        irValid;
  logic        stall;
  logic [1:0]  dbgState;

  ifetch_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) mem_bus ();

  ifetch_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .OPCODE_WIDTH(7), .PC_RESET(16'h0000)
  ) dut (
    .clock(clock), .notReset(notReset), .fetchStart(fetchStart),
    .pcLoad(pcLoad), .pcIn(pcIn), .flagsLoad(flagsLoad),
    .aluCarry(aluCarry), .aluZero(aluZero), .mem(mem_bus.master),
    .opcode(opcode), .operand(operand), .carry(carry), .zero(zero),
    .irValid(irValid), .stall(stall), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model / scoreboard ----------------
  int          n_cmp;
  int          n_fail;
  logic [15:0] exp_pc;
  logic [15:0] exp_ir;
  logic        exp_carry;
  logic        exp_zero;
  logic [15:0] exp_q[$];

  // One clock edge; inputs are set at posedge+1 and outputs sampled there.
  // The flag model is a plain "load when enabled" register.
  task automatic tick();
    logic fl, ac, az;
    fl = flagsLoad; ac = aluCarry; az = aluZero;
    @(posedge clock);
    #1;
    if (fl) begin
      exp_carry = ac;
      exp_zero  = az;
    end
  endtask

  task automatic idle_inputs();
    fetchStart = 0; pcLoad = 0; pcIn = 0; flagsLoad = 0;
    aluCarry = 0; aluZero = 0;
    mem_bus.memAck = 0; mem_bus.memData = 0;
  endtask

  task automatic load_pc(input logic [15:0] addr);
    pcLoad = 1; pcIn = addr;
    tick();
    pcLoad = 0;
    exp_pc = addr;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    notReset = 0;
    #3;
    notReset = 1;
    tick();
    exp_pc = 16'h0000; exp_ir = 16'h0000; exp_carry = 0; exp_zero = 0;
    n_cmp++;
    if (mem_bus.memReq !== 1'b0 || stall !== 1'b0 || irValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%b stall=%b irv=%b want 0/0/0", mem_bus.memReq, stall, irValid);
    end
    n_cmp++;
    if (mem_bus.memAddr !== 16'h0000 || opcode !== 7'h00 || operand !== 9'h000 ||
        carry !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: addr=%h op=%h opd=%h c=%b z=%b want zeros",
               mem_bus.memAddr, opcode, operand, carry, zero);
    end
  endtask

  task automatic test_zero_wait();
    int stall_cycles;
    load_pc(16'h0010);
    n_cmp++;
    if (mem_bus.memAddr !== 16'h0010) begin
      n_fail++; $display("FAIL zw_pcload: addr=%h want 0010", mem_bus.memAddr);
    end
    mem_bus.memAck = 1; mem_bus.memData = 16'hA5C3; fetchStart = 1;
    tick();
    fetchStart = 0;
    stall_cycles = stall ? 1 : 0;
    n_cmp++;
    if (mem_bus.memReq !== 1'b1 || stall !== 1'b1 || irValid !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_req: req=%b stall=%b irv=%b want 1/1/0", mem_bus.memReq, stall, irValid);
    end
    tick();
    mem_bus.memAck = 0;
    if (stall) stall_cycles++;
    n_cmp++;
    if (opcode !== 7'h52 || operand !== 9'h1C3) begin
      n_fail++; $display("FAIL zw_ir: op=%h opd=%h want 52/1c3", opcode, operand);
    end
    n_cmp++;
    if (mem_bus.memAddr !== 16'h0011 || irValid !== 1'b1 || mem_bus.memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_done: addr=%h irv=%b req=%b want 0011/1/0", mem_bus.memAddr, irValid, mem_bus.memReq);
    end
    tick();
    if (stall) stall_cycles++;
    n_cmp++;
    if (irValid !== 1'b0 || stall_cycles != 1) begin
      n_fail++; $display("FAIL zw_pulse: irv=%b stall_cycles=%0d want 0/1", irValid, stall_cycles);
    end
    exp_pc = 16'h0011; exp_ir = 16'hA5C3;
  endtask

  task automatic test_wait_states();
    logic [15:0] p;
    logic [15:0] d;
    int updates;
    p = 16'($urandom_range(16'h0100, 16'hF000));
    d = 16'($urandom);
    load_pc(p);
    fetchStart = 1;
    tick();
    // Ignored during FETCH: a jump and a second fetch request.
    pcLoad = 1; pcIn = 16'h1234; fetchStart = 1;
    updates = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem_bus.memReq !== 1'b1 || mem_bus.memAddr !== p || irValid !== 1'b0) begin
        n_fail++;
        $display("FAIL ws_hold%0d: req=%b addr=%h irv=%b want 1/%h/0", i, mem_bus.memReq, mem_bus.memAddr, irValid, p);
      end
      if (i == 2) begin
        mem_bus.memAck = 1; mem_bus.memData = d;
      end
      tick();
      if (irValid) updates++;
    end
    mem_bus.memAck = 0; pcLoad = 0; fetchStart = 0;
    exp_pc = p + 16'd1; exp_ir = d;
    n_cmp++;
    if ({opcode, operand} !== exp_ir || mem_bus.memAddr !== exp_pc) begin
      n_fail++;
      $display("FAIL ws_result: ir=%h addr=%h want %h/%h", {opcode, operand}, mem_bus.memAddr, exp_ir, exp_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (irValid) updates++;
    end
    n_cmp++;
    if (updates != 1 || mem_bus.memReq !== 1'b0 || mem_bus.memAddr !== exp_pc) begin
      n_fail++;
      $display("FAIL ws_single: updates=%0d req=%b addr=%h want 1/0/%h", updates, mem_bus.memReq, mem_bus.memAddr, exp_pc);
    end
  endtask

  task automatic test_wrap_priority();
    logic [15:0] d;
    d = 16'($urandom);
    load_pc(16'hFFFF);
    fetchStart = 1;
    tick();
    fetchStart = 0;
    mem_bus.memAck = 1; mem_bus.memData = d;
    tick();
    mem_bus.memAck = 0;
    n_cmp++;
    if (mem_bus.memAddr !== 16'h0000 || irValid !== 1'b1) begin
      n_fail++; $display("FAIL wrap: addr=%h irv=%b want 0000/1", mem_bus.memAddr, irValid);
    end
    // In DONE: jump and fetch together; the fetch must use the jump target.
    pcLoad = 1; pcIn = 16'h0200; fetchStart = 1;
    tick();
    pcLoad = 0; fetchStart = 0;
    n_cmp++;
    if (mem_bus.memReq !== 1'b1 || mem_bus.memAddr !== 16'h0200) begin
      n_fail++; $display("FAIL prio: req=%b addr=%h want 1/0200", mem_bus.memReq, mem_bus.memAddr);
    end
    d = 16'($urandom);
    mem_bus.memAck = 1; mem_bus.memData = d;
    tick();
    mem_bus.memAck = 0;
    tick();
    exp_pc = 16'h0201; exp_ir = d;
    n_cmp++;
    if (mem_bus.memAddr !== exp_pc || {opcode, operand} !== exp_ir) begin
      n_fail++;
      $display("FAIL prio_fetch: addr=%h ir=%h want %h/%h", mem_bus.memAddr, {opcode, operand}, exp_pc, exp_ir);
    end
  endtask

  task automatic test_flags();
    logic [15:0] d;
    fetchStart = 1;
    tick();
    fetchStart = 0;
    flagsLoad = 1; aluCarry = 1; aluZero = 0;
    tick();
    flagsLoad = 0;
    n_cmp++;
    if (carry !== 1'b1 || zero !== 1'b0 || mem_bus.memReq !== 1'b1 || mem_bus.memAddr !== exp_pc) begin
      n_fail++;
      $display("FAIL flags_load: c=%b z=%b req=%b addr=%h want 1/0/1/%h", carry, zero, mem_bus.memReq, mem_bus.memAddr, exp_pc);
    end
    for (int i = 0; i < 10; i++) begin
      aluCarry = 1'($urandom); aluZero = 1'($urandom);
      tick();
      n_cmp++;
      if (carry !== 1'b1 || zero !== 1'b0) begin
        n_fail++; $display("FAIL flags_hold%0d: c=%b z=%b want 1/0", i, carry, zero);
      end
    end
    d = 16'($urandom);
    mem_bus.memAck = 1; mem_bus.memData = d;
    tick();
    mem_bus.memAck = 0;
    exp_pc = exp_pc + 16'd1; exp_ir = d;
    n_cmp++;
    if ({opcode, operand} !== exp_ir || mem_bus.memAddr !== exp_pc || irValid !== 1'b1) begin
      n_fail++;
      $display("FAIL flags_fetch: ir=%h addr=%h irv=%b want %h/%h/1", {opcode, operand}, mem_bus.memAddr, irValid, exp_ir, exp_pc);
    end
    tick();
  endtask

  task automatic test_spurious_ack();
    mem_bus.memAck = 1; mem_bus.memData = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({opcode, operand} !== exp_ir || mem_bus.memAddr !== exp_pc || irValid !== 1'b0 ||
          mem_bus.memReq !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious%0d: ir=%h addr=%h irv=%b req=%b want %h/%h/0/0",
                 i, {opcode, operand}, mem_bus.memAddr, irValid, mem_bus.memReq, exp_ir, exp_pc);
      end
    end
    mem_bus.memAck = 0;
  endtask

  // Randomised fetch sequence: random jumps, wait states, data and flags.
  task automatic test_random();
    int w;
    logic [15:0] d;
    logic [15:0] got;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) load_pc(16'($urandom));
      fetchStart = 1;
      tick();
      fetchStart = 0;
      w = $urandom_range(0, 3);
      for (int i = 0; i <= w; i++) begin
        flagsLoad = 1'($urandom); aluCarry = 1'($urandom); aluZero = 1'($urandom);
        if (i == w) begin
          d = 16'($urandom);
          mem_bus.memAck = 1; mem_bus.memData = d;
          exp_q.push_back(d);
        end
        n_cmp++;
        if (mem_bus.memReq !== 1'b1 || stall !== 1'b1 || mem_bus.memAddr !== exp_pc) begin
          n_fail++;
          $display("FAIL rnd_req%0d: req=%b stall=%b addr=%h want 1/1/%h", n, mem_bus.memReq, stall, mem_bus.memAddr, exp_pc);
        end
        tick();
      end
      mem_bus.memAck = 0; flagsLoad = 0;
      exp_pc = exp_pc + 16'd1;
      got = {opcode, operand};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rnd_q%0d: scoreboard empty", n);
      end else begin
        exp_ir = exp_q.pop_front();
        if (irValid !== 1'b1 || got !== exp_ir || mem_bus.memAddr !== exp_pc ||
            carry !== exp_carry || zero !== exp_zero) begin
          n_fail++;
          $display("FAIL rnd_done%0d: irv=%b ir=%h addr=%h c=%b z=%b want 1/%h/%h/%b/%b",
                   n, irValid, got, mem_bus.memAddr, carry, zero, exp_ir, exp_pc, exp_carry, exp_zero);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_fetch();
    fetchStart = 1;
    tick();
    fetchStart = 0;
    n_cmp++;
    if (mem_bus.memReq !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: req=%b want 1", mem_bus.memReq);
    end
    // Assert reset between edges: outputs must clear without a clock.
    mem_bus.memAck = 0;
    notReset = 0;
    #1;
    exp_pc = 16'h0000; exp_ir = 16'h0000; exp_carry = 0; exp_zero = 0;
    n_cmp++;
    if (mem_bus.memReq !== 1'b0 || stall !== 1'b0 || mem_bus.memAddr !== 16'h0000 ||
        opcode !== 7'h00 || operand !== 9'h000 || carry !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: req=%b stall=%b addr=%h op=%h opd=%h c=%b z=%b want all 0",
               mem_bus.memReq, stall, mem_bus.memAddr, opcode, operand, carry, zero);
    end
    mem_bus.memAck = 1; mem_bus.memData = 16'h5A5A;
    #1;
    notReset = 1;
    tick();
    tick();
    mem_bus.memAck = 0;
    n_cmp++;
    if (mem_bus.memReq !== 1'b0 || stall !== 1'b0 || irValid !== 1'b0 ||
        mem_bus.memAddr !== 16'h0000 || {opcode, operand} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_idle: req=%b stall=%b irv=%b addr=%h ir=%h want 0/0/0/0000/0000",
               mem_bus.memReq, stall, irValid, mem_bus.memAddr, {opcode, operand});
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    notReset = 1;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_wrap_priority();
    test_flags();
    test_spurious_ack();
    test_random();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
